// File: rtl/dogbattle_pkg.sv
// Shared types, screen limits and helpers for the dogbattle game engine.
package dogbattle_pkg;

    localparam int unsigned NUM_DOGS  = 8;
    localparam int unsigned NUM_PAIRS = 28;
    localparam int          X_MAX     = 639;
    localparam int          Y_MAX     = 479;
    localparam int          DOG_PX    = 16;

    localparam logic signed [11:0] DOG_SIZE = 12'(DOG_PX);
    localparam logic signed [11:0] X_LIM    = 12'(X_MAX - DOG_PX + 1);
    localparam logic signed [11:0] Y_LIM    = 12'(Y_MAX - DOG_PX + 1);
    localparam logic signed [11:0] GRAVITY  = 12'sd1;
    localparam logic signed [11:0] VMAX     = 12'sd15;
    localparam logic [1:0]         HP_INIT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        COLLIDE
    } engine_state_t;

    typedef struct packed {
        logic [9:0]        x;
        logic [9:0]        y;
        logic signed [4:0] vx;
        logic signed [4:0] vy;
        logic [1:0]        hp;
        logic              alive;
    } dog_state_t;

    typedef struct packed {
        logic [2:0] i;
        logic [2:0] j;
    } dog_pair_t;

    // Each octal literal packs {i, j}; lexicographic over all i < j.
    localparam logic [5:0] PAIR_ROM [NUM_PAIRS] = '{
        6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06, 6'o07,
        6'o12, 6'o13, 6'o14, 6'o15, 6'o16, 6'o17,
        6'o23, 6'o24, 6'o25, 6'o26, 6'o27,
        6'o34, 6'o35, 6'o36, 6'o37,
        6'o45, 6'o46, 6'o47,
        6'o56, 6'o57,
        6'o67
    };

    function automatic dog_pair_t pair_at(input logic [4:0] k);
        return dog_pair_t'(PAIR_ROM[k]);
    endfunction

    function automatic logic signed [4:0] sat_vel(input logic signed [11:0] v);
        if (v > VMAX) begin
            return 5'sd15;
        end else if (v < -VMAX) begin
            return -5'sd15;
        end
        return v[4:0];
    endfunction

    function automatic dog_state_t dog_reset(input int unsigned i);
        dog_state_t d;
        d.x     = 10'(16 + 72 * i);
        d.y     = 10'd40;
        d.vx    = i[0] ? -5'sd3 : 5'sd3;
        d.vy    = '0;
        d.hp    = HP_INIT;
        d.alive = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/dog_motion_step.sv
// Combinational single-dog frame step: gravity, motion and wall/floor bounce.
module dog_motion_step
    import dogbattle_pkg::*;
(
    input  dog_state_t cur,
    output dog_state_t nxt
);

    logic signed [11:0] vy_ext;
    logic signed [11:0] vx_ext;
    logic signed [4:0]  vy_sat;
    logic signed [11:0] vy_sat_ext;
    logic signed [11:0] y_new;
    logic signed [11:0] x_new;

    always_comb begin
        nxt        = cur;
        vy_ext     = $signed({{7{cur.vy[4]}}, cur.vy});
        vx_ext     = $signed({{7{cur.vx[4]}}, cur.vx});
        vy_sat     = sat_vel(vy_ext + GRAVITY);
        vy_sat_ext = $signed({{7{vy_sat[4]}}, vy_sat});
        y_new      = $signed({2'b00, cur.y}) + vy_sat_ext;
        x_new      = $signed({2'b00, cur.x}) + vx_ext;

        if (cur.alive) begin
            if (y_new > Y_LIM) begin
                nxt.y  = Y_LIM[9:0];
                nxt.vy = -vy_sat;
            end else if (y_new[11]) begin
                nxt.y  = '0;
                nxt.vy = -vy_sat;
            end else begin
                nxt.y  = y_new[9:0];
                nxt.vy = vy_sat;
            end

            if (x_new[11]) begin
                nxt.x  = '0;
                nxt.vx = -cur.vx;
            end else if (x_new > X_LIM) begin
                nxt.x  = X_LIM[9:0];
                nxt.vx = -cur.vx;
            end else begin
                nxt.x = x_new[9:0];
            end
        end
    end

endmodule

// File: rtl/dog_physics_engine.sv
// Per-frame dog battle engine: moves every dog, then resolves all pair collisions.
module dog_physics_engine
    import dogbattle_pkg::*;
(
    input  logic       clk50,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [2:0] rd_idx,
    output logic [9:0] rd_x,
    output logic [9:0] rd_y,
    output logic [1:0] rd_hp,
    output logic       rd_alive,
    output logic       busy,
    output logic       overrun,
    output logic [3:0] alive_count,
    output logic       game_over,
    output logic [7:0] frame_count
);

    engine_state_t state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [4:0]    pair_q, pair_d;
    dog_state_t    dogs_q [NUM_DOGS];
    dog_state_t    dogs_d [NUM_DOGS];
    logic [7:0]    frame_count_q, frame_count_d;
    logic [3:0]    alive_count_q, alive_count_d;
    logic          game_over_q, game_over_d;

    dog_state_t         step_cur, step_nxt;
    dog_pair_t          pair;
    dog_state_t         dog_a, dog_b;
    logic signed [11:0] dx, dy, adx, ady;
    logic               hit;

    assign step_cur = dogs_q[idx_q];

    dog_motion_step u_motion (
        .cur (step_cur),
        .nxt (step_nxt)
    );

    // Pair resolution works on the current registers, so earlier hits this frame are seen.
    always_comb begin : collide_eval
        pair  = pair_at(pair_q);
        dog_a = dogs_q[pair.i];
        dog_b = dogs_q[pair.j];
        dx    = $signed({2'b00, dog_a.x}) - $signed({2'b00, dog_b.x});
        dy    = $signed({2'b00, dog_a.y}) - $signed({2'b00, dog_b.y});
        adx   = dx[11] ? -dx : dx;
        ady   = dy[11] ? -dy : dy;
        hit   = dog_a.alive && dog_b.alive && (adx < DOG_SIZE) && (ady < DOG_SIZE);
        if (hit) begin
            dog_a.vx    = -dog_a.vx;
            dog_b.vx    = -dog_b.vx;
            dog_a.hp    = (dog_a.hp == 2'd0) ? 2'd0 : dog_a.hp - 2'd1;
            dog_b.hp    = (dog_b.hp == 2'd0) ? 2'd0 : dog_b.hp - 2'd1;
            dog_a.alive = (dog_a.hp != 2'd0);
            dog_b.alive = (dog_b.hp != 2'd0);
        end
    end

    always_comb begin : next_state
        state_d       = state_q;
        idx_d         = idx_q;
        pair_d        = pair_q;
        frame_count_d = frame_count_q;
        dogs_d        = dogs_q;

        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d       = MOVE;
                    idx_d         = '0;
                    frame_count_d = frame_count_q + 8'd1;
                end
            end
            MOVE: begin
                dogs_d[idx_q] = step_nxt;
                if (idx_q == 3'(NUM_DOGS - 1)) begin
                    state_d = COLLIDE;
                    pair_d  = '0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            COLLIDE: begin
                dogs_d[pair.i] = dog_a;
                dogs_d[pair.j] = dog_b;
                if (pair_q == 5'(NUM_PAIRS - 1)) begin
                    state_d = IDLE;
                end else begin
                    pair_d = pair_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        alive_count_d = '0;
        for (int unsigned i = 0; i < NUM_DOGS; i++) begin
            alive_count_d = alive_count_d + {3'b000, dogs_q[i].alive};
        end
        game_over_d = (alive_count_d <= 4'd1);
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            pair_q        <= '0;
            frame_count_q <= '0;
            alive_count_q <= 4'(NUM_DOGS);
            game_over_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_DOGS; i++) begin
                dogs_q[i] <= dog_reset(i);
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pair_q        <= pair_d;
            frame_count_q <= frame_count_d;
            alive_count_q <= alive_count_d;
            game_over_q   <= game_over_d;
            dogs_q        <= dogs_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign overrun     = frame_tick && busy;
    assign alive_count = alive_count_q;
    assign game_over   = game_over_q;
    assign frame_count = frame_count_q;
    assign rd_x        = dogs_q[rd_idx].x;
    assign rd_y        = dogs_q[rd_idx].y;
    assign rd_hp       = dogs_q[rd_idx].hp;
    assign rd_alive    = dogs_q[rd_idx].alive;

endmodule

// File: tb/tb_dog_physics_engine.sv
// Self-checking bench for dog_physics_engine against an integer game model.
module tb_dog_physics_engine;

    logic       clk50 = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic [2:0] rd_idx;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic [1:0] rd_hp;
    logic       rd_alive;
    logic       busy;
    logic       overrun;
    logic [3:0] alive_count;
    logic       game_over;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;

    int mx [8];
    int my [8];
    int mvx [8];
    int mvy [8];
    int mhp [8];
    int malive [8];
    int mframes;

    dog_physics_engine dut (
        .clk50       (clk50),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .rd_idx      (rd_idx),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_hp       (rd_hp),
        .rd_alive    (rd_alive),
        .busy        (busy),
        .overrun     (overrun),
        .alive_count (alive_count),
        .game_over   (game_over),
        .frame_count (frame_count)
    );

    always #10 clk50 = ~clk50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            mx[i]     = 16 + 72 * i;
            my[i]     = 40;
            mvx[i]    = (i % 2 == 0) ? 3 : -3;
            mvy[i]    = 0;
            mhp[i]    = 3;
            malive[i] = 1;
        end
        mframes = 0;
    endfunction

    function automatic int model_alive();
        int n = 0;
        for (int i = 0; i < 8; i++) n += malive[i];
        return n;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_frame();
        int v, ny, nx;
        mframes = (mframes + 1) % 256;
        for (int i = 0; i < 8; i++) begin
            if (malive[i] == 0) continue;
            v = mvy[i] + 1;
            if (v > 15) v = 15;
            if (v < -15) v = -15;
            ny = my[i] + v;
            if (ny > 464) begin my[i] = 464; mvy[i] = -v; end
            else if (ny < 0) begin my[i] = 0; mvy[i] = -v; end
            else begin my[i] = ny; mvy[i] = v; end
            nx = mx[i] + mvx[i];
            if (nx < 0) begin mx[i] = 0; mvx[i] = -mvx[i]; end
            else if (nx > 624) begin mx[i] = 624; mvx[i] = -mvx[i]; end
            else mx[i] = nx;
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                if (malive[i] != 0 && malive[j] != 0 &&
                    iabs(mx[i] - mx[j]) < 16 && iabs(my[i] - my[j]) < 16) begin
                    mvx[i] = -mvx[i];
                    mvx[j] = -mvx[j];
                    if (mhp[i] > 0) mhp[i]--;
                    if (mhp[j] > 0) mhp[j]--;
                    malive[i] = (mhp[i] > 0) ? 1 : 0;
                    malive[j] = (mhp[j] > 0) ? 1 : 0;
                end
            end
        end
    endfunction

    task automatic read_dog(input int i);
        rd_idx = 3'(i);
        #1;
    endtask

    task automatic check_all_dogs(input string phase);
        int start = int'($urandom_range(0, 7));
        int i;
        for (int k = 0; k < 8; k++) begin
            i = (start + k) % 8;
            read_dog(i);
            check($sformatf("%s x[%0d]", phase, i), rd_x, mx[i]);
            check($sformatf("%s y[%0d]", phase, i), rd_y, my[i]);
            check($sformatf("%s hp[%0d]", phase, i), rd_hp, mhp[i]);
            check($sformatf("%s alive[%0d]", phase, i), rd_alive, malive[i]);
        end
    endtask

    // inject_at: busy cycle (1..36) in which a second tick is raised, 0 for none.
    task automatic run_frame(input int inject_at);
        int cyc;
        repeat ($urandom_range(0, 3)) @(posedge clk50);
        @(posedge clk50);
        #1;
        frame_tick = 1'b1;
        #1;
        check("idle_tick_overrun", overrun, 0);
        @(posedge clk50);
        #1;
        frame_tick = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == inject_at) begin
                frame_tick = 1'b1;
                #1;
                check("overrun_pulse", overrun, 1);
            end
            @(posedge clk50);
            #1;
            frame_tick = 1'b0;
        end
        check("busy_cycles", cyc, 36);
        @(posedge clk50);
        #1;
        model_frame();
        check("frame_count", frame_count, mframes);
        check("alive_count", alive_count, model_alive());
        check("game_over", game_over, (model_alive() <= 1) ? 1 : 0);
        check("busy_idle", busy, 0);
        check_all_dogs($sformatf("f%0d", mframes));
    endtask

    function automatic int pick_inject();
        return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 36)) : 0;
    endfunction

    initial begin
        #1900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        rd_idx     = '0;
        model_reset();
        repeat (3) @(posedge clk50);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_alive_count", alive_count, 8);
        check("rst_game_over", game_over, 0);
        read_dog(3);
        check("rst_dog3_x", rd_x, 232);
        check("rst_dog3_y", rd_y, 40);
        check("rst_dog3_hp", rd_hp, 3);
        check_all_dogs("rst");

        for (int f = 1; f <= 40; f++) begin
            run_frame((f == 5) ? 5 : pick_inject());
            if (f == 1) begin
                read_dog(0);
                check("f1_dog0_x", rd_x, 19);
                check("f1_dog0_y", rd_y, 41);
                read_dog(1);
                check("f1_dog1_x", rd_x, 85);
                check("f1_frame_count", frame_count, 1);
            end
            if (f == 10) begin
                read_dog(0);
                check("f10_dog0_x", rd_x, 46);
                check("f10_dog0_hp", rd_hp, 2);
                check("f10_dog0_y", rd_y, 95);
                read_dog(1);
                check("f10_dog1_x", rd_x, 58);
                check("f10_dog1_hp", rd_hp, 2);
            end
            if (f == 11) begin
                read_dog(0);
                check("f11_dog0_x", rd_x, 43);
                read_dog(1);
                check("f11_dog1_x", rd_x, 61);
            end
            if (f == 26) begin
                read_dog(0);
                check("f26_dog0_x", rd_x, 0);
            end
            if (f == 27) begin
                read_dog(0);
                check("f27_dog0_x", rd_x, 3);
            end
            if (f == 36) begin
                read_dog(0);
                check("f36_dog0_y", rd_y, 464);
            end
            if (f == 37) begin
                read_dog(0);
                check("f37_dog0_y", rd_y, 450);
            end
        end

        // Abort an update partway through with an asynchronous reset.
        for (int r = 0; r < 2; r++) begin
            @(posedge clk50);
            #1;
            frame_tick = 1'b1;
            @(posedge clk50);
            #1;
            frame_tick = 1'b0;
            repeat ((r == 0) ? 18 : int'($urandom_range(1, 34))) @(posedge clk50);
            #1;
            check("busy_before_rst", busy, 1);
            rst_n = 1'b0;
            #1;
            model_reset();
            check("midrst_busy", busy, 0);
            check("midrst_frame_count", frame_count, 0);
            check("midrst_alive_count", alive_count, 8);
            read_dog(0);
            check("midrst_dog0_x", rd_x, 16);
            check("midrst_dog0_hp", rd_hp, 3);
            @(posedge clk50);
            #1;
            rst_n = 1'b1;
            check_all_dogs("midrst");
        end

        for (int f = 0; f < 700 && model_alive() > 1; f++) begin
            run_frame(pick_inject());
        end
        check("final_alive_count", alive_count, model_alive());
        check("final_game_over", game_over, (model_alive() <= 1) ? 1 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
